// File: rtl/accel_pkg.sv
// Shared types and register-map constants for the systolic MAC sequencer.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FEED   = 2'd2,
    WAIT   = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] REG_R = 2'd0;
  localparam logic [1:0] A_R   = 2'd1;
  localparam logic [1:0] B_R   = 2'd2;
  localparam logic [1:0] C_R   = 2'd3;

  localparam logic [5:0] CTRL_IDX   = 6'd0;
  localparam logic [5:0] STATUS_IDX = 6'd1;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_TIMEOUT = 2;
  localparam int STATUS_ERR     = 3;

endpackage

// File: rtl/accel_regfile.sv
// N*N x W operand buffer: one write port, two combinational read ports.
// Out-of-range read indices return 0; out-of-range writes are dropped.
module accel_regfile #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [5:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [5:0]   raddr_a,
  output logic [W-1:0] rdata_a,
  input  logic [5:0]   raddr_b,
  output logic [W-1:0] rdata_b
);

  localparam int         D    = N * N;
  localparam int         IW   = (D > 1) ? $clog2(D) : 1;
  localparam logic [5:0] LAST = 6'(D - 1);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (we && (waddr <= LAST)) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  assign rdata_a = (raddr_a <= LAST) ? mem[raddr_a[IW-1:0]] : '0;
  assign rdata_b = (raddr_b <= LAST) ? mem[raddr_b[IW-1:0]] : '0;

endmodule

// File: rtl/accel_ctrl.sv
// Memory-mapped sequencer: host loads A/B, a CTRL start streams N*N operand
// pairs into the MAC core, then the result (or a timeout) is captured.
module accel_ctrl
  import accel_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int AW      = 8,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [W-1:0]     req_wdata,
  output logic             rsp_valid,
  output logic [W-1:0]     rsp_rdata,
  output logic             core_start,
  output logic             core_in_valid,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  input  logic             core_done,
  input  logic [N*N*W-1:0] core_result,
  output logic             irq
);

  localparam int              D      = N * N;
  localparam int              IW     = (D > 1) ? $clog2(D) : 1;
  localparam logic [5:0]      LAST   = 6'(D - 1);
  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  ctrl_state_e   state_q, state_d;
  logic [5:0]    feed_idx_q;
  logic [TW-1:0] timer_q;
  logic          done_q, timeout_q, err_q, irq_en_q;
  logic [W-1:0]  c_q [D];

  logic [1:0]    region;
  logic [5:0]    idx;
  logic          wr, rd, ctrl_wr, start_req, clr_req, busy;
  logic          ab_wr, a_we, b_we, busy_viol, launch;
  logic          finish_ok, finish_to;
  logic [W-1:0]  a_host, b_host, a_feed, b_feed, rd_data;

  assign req_ready = 1'b1;
  assign region    = req_addr[AW-1 -: 2];
  assign idx       = req_addr[5:0];
  assign wr        = req_valid & req_we;
  assign rd        = req_valid & ~req_we;
  assign busy      = (state_q != IDLE);

  assign ctrl_wr   = wr && (region == REG_R) && (idx == CTRL_IDX);
  assign start_req = ctrl_wr & req_wdata[CTRL_START];
  assign clr_req   = ctrl_wr & req_wdata[CTRL_CLR];
  assign ab_wr     = wr && ((region == A_R) || (region == B_R));
  assign a_we      = wr && (region == A_R) && !busy;
  assign b_we      = wr && (region == B_R) && !busy;
  assign busy_viol = busy & (ab_wr | start_req);
  assign launch    = start_req & ~busy;

  accel_regfile #(.N(N), .W(W)) u_a_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (a_we),
    .waddr   (idx),
    .wdata   (req_wdata),
    .raddr_a (idx),
    .rdata_a (a_host),
    .raddr_b (feed_idx_q),
    .rdata_b (a_feed)
  );

  accel_regfile #(.N(N), .W(W)) u_b_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (b_we),
    .waddr   (idx),
    .wdata   (req_wdata),
    .raddr_a (idx),
    .rdata_a (b_host),
    .raddr_b (feed_idx_q),
    .rdata_b (b_feed)
  );

  always_comb begin
    state_d       = state_q;
    core_start    = 1'b0;
    core_in_valid = 1'b0;
    finish_ok     = 1'b0;
    finish_to     = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) state_d = LAUNCH;
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_d    = FEED;
      end
      FEED: begin
        core_in_valid = 1'b1;
        if (feed_idx_q == LAST) state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the final timer cycle still counts as success.
        if (core_done) begin
          finish_ok = 1'b1;
          state_d   = IDLE;
        end else if (timer_q == T_LAST) begin
          finish_to = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_a = core_in_valid ? a_feed : '0;
  assign core_b = core_in_valid ? b_feed : '0;
  assign irq    = irq_en_q & done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      feed_idx_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      feed_idx_q <= (state_q == FEED) ? feed_idx_q + 6'd1 : '0;
      timer_q    <= (state_q == WAIT) ? timer_q + 1'b1 : '0;
    end
  end

  // Later assignments win: run-completion and busy violations override a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= req_wdata[CTRL_IRQ_EN];
      if (clr_req || launch) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        err_q     <= 1'b0;
      end
      if (busy_viol) err_q <= 1'b1;
      if (finish_ok) done_q <= 1'b1;
      if (finish_to) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) c_q[i] <= '0;
    end else if (finish_ok) begin
      for (int i = 0; i < D; i++) c_q[i] <= core_result[i*W +: W];
    end
  end

  always_comb begin
    rd_data = '0;
    case (region)
      REG_R: begin
        if (idx == CTRL_IDX) begin
          rd_data[CTRL_IRQ_EN] = irq_en_q;
        end else if (idx == STATUS_IDX) begin
          rd_data[STATUS_BUSY]    = busy;
          rd_data[STATUS_DONE]    = done_q;
          rd_data[STATUS_TIMEOUT] = timeout_q;
          rd_data[STATUS_ERR]     = err_q;
        end
      end
      A_R:     rd_data = a_host;
      B_R:     rd_data = b_host;
      C_R:     rd_data = (idx <= LAST) ? c_q[idx[IW-1:0]] : '0;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_valid <= 1'b0;
    else        rsp_valid <= rd;
  end

  always_ff @(posedge clk) begin
    if (rd) rsp_rdata <= rd_data;
  end

endmodule

// File: tb/tb_accel_ctrl.sv
// Scoreboard bench for accel_ctrl with a stub MAC core answering after 24 cycles.
module tb_accel_ctrl;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int TO = 64;

  localparam logic [7:0] CTRL   = 8'h00;
  localparam logic [7:0] STATUS = 8'h01;
  localparam logic [7:0] A_BASE = 8'h40;
  localparam logic [7:0] B_BASE = 8'h80;
  localparam logic [7:0] C_BASE = 8'hC0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [W-1:0]     req_wdata = '0;
  logic             rsp_valid;
  logic [W-1:0]     rsp_rdata;
  logic             core_start;
  logic             core_in_valid;
  logic [W-1:0]     core_a;
  logic [W-1:0]     core_b;
  logic             core_done = 1'b0;
  logic [N*N*W-1:0] core_result = '0;
  logic             irq;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int stub_cnt = 0;
  bit stub_en = 1'b0;
  int starts_before;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [31:0] feed_a_q[$];
  logic [31:0] feed_b_q[$];

  accel_ctrl #(.N(N), .W(W), .AW(AW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .core_start    (core_start),
    .core_in_valid (core_in_valid),
    .core_a        (core_a),
    .core_b        (core_b),
    .core_done     (core_done),
    .core_result   (core_result),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Monitor: pops expected read data and feed pairs as the DUT presents them.
  initial begin
    logic [31:0] e;
    logic [31:0] eb;
    string nm;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rd_exp_q.size() == 0) begin
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          e  = rd_exp_q.pop_front();
          nm = rd_name_q.pop_front();
          check(nm, rsp_rdata, e);
        end
      end
      if (core_in_valid && feed_a_q.size() != 0) begin
        e  = feed_a_q.pop_front();
        eb = feed_b_q.pop_front();
        check("feed_a", core_a, e);
        check("feed_b", core_b, eb);
      end
      if (core_start) start_cnt++;
    end
  end

  // Stub core: core_done pulses 24 cycles after each start pulse.
  initial begin
    for (int i = 0; i < N*N; i++) core_result[i*W +: W] = 32'h100 + 32'(i);
    forever begin
      @(negedge clk);
      if (stub_cnt > 0) begin
        stub_cnt--;
        core_done = (stub_cnt == 0);
      end else begin
        core_done = 1'b0;
      end
      if (core_start && stub_en) stub_cnt = 24;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and unmapped / out-of-range reads
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_in_valid", 32'(core_in_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("req_ready", 32'(req_ready), 32'd1);
    bus_read(STATUS, 32'h0, "rst_status");
    bus_read(CTRL, 32'h0, "rst_ctrl");
    bus_read(A_BASE + 8'd3, 32'h0, "rst_a3");
    bus_read(C_BASE, 32'h0, "rst_c0");
    bus_read(8'h02, 32'h0, "unmapped_reg");
    bus_read(A_BASE + 8'd20, 32'h0, "a_idx_out_of_range");

    // Test 1: feed order
    for (int k = 0; k < 16; k++) begin
      bus_write(A_BASE + 8'(k), 32'(k + 1));
      bus_write(B_BASE + 8'(k), 32'(16 - k));
      feed_a_q.push_back(32'(k + 1));
      feed_b_q.push_back(32'(16 - k));
    end
    bus_read(A_BASE, 32'd1, "a0_readback");
    bus_read(B_BASE + 8'd15, 32'd1, "b15_readback");
    stub_en = 1'b1;
    starts_before = start_cnt;
    bus_write(CTRL, 32'h1);
    check("t1_start_at_T", 32'(core_start), 32'd1);
    check("t1_valid_at_T", 32'(core_in_valid), 32'd0);
    check("t1_core_a_idle", core_a, 32'd0);
    @(posedge clk); #1;
    check("t1_start_T1", 32'(core_start), 32'd0);
    check("t1_valid_T1", 32'(core_in_valid), 32'd1);
    repeat (16) @(posedge clk);
    #1;
    check("t1_valid_T17", 32'(core_in_valid), 32'd0);
    check("t1_feed_drained", 32'(feed_a_q.size()), 32'd0);
    check("t1_one_start", 32'(start_cnt - starts_before), 32'd1);

    // Test 2: completion capture (now at T+17, done arrives at T+24)
    repeat (9) @(posedge clk);
    #1;
    bus_read(STATUS, 32'h2, "t2_status");
    bus_read(C_BASE + 8'd5, 32'h105, "t2_c5");
    bus_read(C_BASE, 32'h100, "t2_c0");
    check("t2_irq_disabled", 32'(irq), 32'd0);
    bus_write(C_BASE + 8'd5, 32'h0);
    bus_read(C_BASE + 8'd5, 32'h105, "t2_c_write_dropped");
    bus_write(CTRL, 32'h4);
    check("t2_irq_enabled", 32'(irq), 32'd1);
    bus_read(CTRL, 32'h4, "t2_ctrl_irq_en");

    // Test 6: clr_done
    bus_write(CTRL, 32'h6);
    check("t6_irq_cleared", 32'(irq), 32'd0);
    check("t6_no_rsp_after_write", 32'(rsp_valid), 32'd0);
    bus_read(STATUS, 32'h0, "t6_status");
    check("t6_rsp_valid_after_read", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    check("t6_rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);

    // Test 3: timeout, WAIT entry at T+17
    stub_en = 1'b0;
    bus_write(CTRL, 32'h1);
    repeat (80) @(posedge clk);
    #1;
    bus_read(STATUS, 32'h1, "t3_busy_at_63");
    bus_read(STATUS, 32'h6, "t3_timeout_at_64");
    bus_read(C_BASE + 8'd5, 32'h105, "t3_c_unchanged");

    // Test 4: busy protection
    stub_en = 1'b1;
    starts_before = start_cnt;
    bus_write(CTRL, 32'h1);
    @(posedge clk); #1;
    bus_write(A_BASE, 32'hDEAD);
    repeat (16) @(posedge clk);
    #1;
    bus_write(CTRL, 32'h1);
    repeat (8) @(posedge clk);
    #1;
    bus_read(STATUS, 32'hA, "t4_status_err_done");
    bus_read(A_BASE, 32'd1, "t4_a0_preserved");
    check("t4_no_extra_start", 32'(start_cnt - starts_before), 32'd1);

    // Test 5: reset mid-FEED at idx 7
    stub_en = 1'b0;
    bus_write(CTRL, 32'h1);
    repeat (8) @(posedge clk);
    #1;
    check("t5_feeding", 32'(core_in_valid), 32'd1);
    check("t5_core_a_idx7", core_a, 32'd8);
    rst_n = 1'b0;
    #1;
    check("t5_valid_in_reset", 32'(core_in_valid), 32'd0);
    check("t5_start_in_reset", 32'(core_start), 32'd0);
    check("t5_core_a_in_reset", core_a, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_read(STATUS, 32'h0, "t5_status");
    bus_read(A_BASE, 32'h0, "t5_a0_cleared");
    bus_read(CTRL, 32'h0, "t5_ctrl_cleared");
    bus_read(C_BASE + 8'd5, 32'h0, "t5_c5_cleared");

    @(posedge clk); #1;
    check("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
